// File: rtl/ascii_to_bcd_parser.sv
// rtl/ascii_to_bcd_parser.sv - assembles ASCII decimal digits into a packed BCD word, emitted on a terminator.
// Optional sign support is enabled by defining ASCII_BCD_SIGN_EN (adds out_neg).
module ascii_to_bcd_parser #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_char,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [CNT_W-1:0]        out_digits,
`ifdef ASCII_BCD_SIGN_EN
    output logic                    out_neg,
`endif
    output logic                    out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e                  state_q;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    err_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [4*NUM_DIGITS-1:0] out_bcd_q;
    logic [CNT_W-1:0]        out_digits_q;
    logic                    out_err_q;
`ifdef ASCII_BCD_SIGN_EN
    logic                    neg_q;
    logic                    out_neg_q;
    logic                    is_minus;
`endif

    logic accept;
    logic is_digit;
    logic is_term;
    logic full;

    assign accept   = in_valid && in_ready_q;
    assign is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign is_term  = (in_char == 8'h0D) || (in_char == 8'h0A) || (in_char == 8'h20);
    assign full     = (cnt_q == CNT_W'(NUM_DIGITS));
`ifdef ASCII_BCD_SIGN_EN
    assign is_minus = (in_char == 8'h2D);
`endif

    // Internal word and output registers live in one block; outputs only load on a terminator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bcd_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bcd_q    <= '0;
            out_digits_q <= '0;
            out_err_q    <= 1'b0;
`ifdef ASCII_BCD_SIGN_EN
            neg_q        <= 1'b0;
            out_neg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (is_digit) begin
                            if (!full) begin
                                bcd_q <= {bcd_q[4*NUM_DIGITS-5:0], in_char[3:0]};
                                cnt_q <= cnt_q + CNT_W'(1);
                            end else begin
                                err_q <= 1'b1;
                            end
                            state_q <= ACCUM;
                        end else if (is_term) begin
                            // A terminator with nothing held (e.g. LF after CR) is dropped.
                            if (state_q == ACCUM) begin
                                out_bcd_q    <= bcd_q;
                                out_digits_q <= cnt_q;
                                out_err_q    <= err_q;
`ifdef ASCII_BCD_SIGN_EN
                                out_neg_q    <= neg_q;
`endif
                                out_valid_q  <= 1'b1;
                                in_ready_q   <= 1'b0;
                                state_q      <= HOLD;
                            end
`ifdef ASCII_BCD_SIGN_EN
                        end else if (is_minus && (state_q == IDLE)) begin
                            neg_q   <= 1'b1;
                            state_q <= ACCUM;
`endif
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        bcd_q       <= '0;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
`ifdef ASCII_BCD_SIGN_EN
                        neg_q       <= 1'b0;
`endif
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_bcd    = out_bcd_q;
    assign out_digits = out_digits_q;
    assign out_err    = out_err_q;
`ifdef ASCII_BCD_SIGN_EN
    assign out_neg    = out_neg_q;
`endif

endmodule

// File: tb/tb_ascii_to_bcd_parser.sv
// tb/tb_ascii_to_bcd_parser.sv - directed bench with a character-level reference model for ascii_to_bcd_parser.
// Build with or without ASCII_BCD_SIGN_EN to match the design.
`timescale 1ns/1ps
module tb_ascii_to_bcd_parser;

    localparam int N = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic          out_valid;
    logic          out_ready;
    logic [4*N-1:0] out_bcd;
    logic [CW-1:0] out_digits;
    logic          out_err;
    logic          out_neg_w;

    ascii_to_bcd_parser #(.NUM_DIGITS(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_digits(out_digits),
`ifdef ASCII_BCD_SIGN_EN
        .out_neg   (out_neg_w),
`endif
        .out_err   (out_err)
    );
`ifndef ASCII_BCD_SIGN_EN
    assign out_neg_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: digits kept as a list, the word is rebuilt with arithmetic at the terminator.
    int   m_digits[$];
    bit   m_active, m_err, m_neg;
    bit   ov_exp, rdy_ok, prev_ov;
    int   cur_bcd, cur_dig;
    bit   cur_err, cur_neg;
    int   nwords = 0;
    int   last_bcd, last_dig;
    bit   last_err, last_neg;

    task automatic model_clear();
        m_digits.delete();
        m_active = 0; m_err = 0; m_neg = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", {31'd0, in_ready}, 0);
            chk("rst_out_valid", {31'd0, out_valid}, 0);
            chk("rst_out_bcd", {16'd0, out_bcd}, 0);
            chk("rst_out_digits", {29'd0, out_digits}, 0);
            chk("rst_out_err", {31'd0, out_err}, 0);
            chk("rst_out_neg", {31'd0, out_neg_w}, 0);
            model_clear();
            ov_exp = 0; rdy_ok = 0; prev_ov = 0;
        end else begin
            bit term_acc;
            chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_ok && !ov_exp});
            chk("out_valid", {31'd0, out_valid}, {31'd0, ov_exp});
            if (ov_exp) begin
                chk("out_bcd", {16'd0, out_bcd}, cur_bcd);
                chk("out_digits", {29'd0, out_digits}, cur_dig);
                chk("out_err", {31'd0, out_err}, {31'd0, cur_err});
                chk("out_neg", {31'd0, out_neg_w}, {31'd0, cur_neg});
            end
            if (out_valid && !prev_ov) begin
                nwords++;
                last_bcd = int'(out_bcd); last_dig = int'(out_digits);
                last_err = out_err; last_neg = out_neg_w;
            end
            prev_ov = out_valid;
            term_acc = 0;
            if (in_valid && in_ready) begin
                if (in_char >= "0" && in_char <= "9") begin
                    if (m_digits.size() < N) m_digits.push_back(int'(in_char) - 48);
                    else m_err = 1;
                    m_active = 1;
                end else if (in_char == 8'h0D || in_char == 8'h0A || in_char == 8'h20) begin
                    if (m_active) begin
                        cur_bcd = 0;
                        foreach (m_digits[k]) cur_bcd = cur_bcd * 16 + m_digits[k];
                        cur_dig = m_digits.size();
                        cur_err = m_err;
                        cur_neg = m_neg;
                        term_acc = 1;
                        model_clear();
                    end
`ifdef ASCII_BCD_SIGN_EN
                end else if (in_char == "-" && !m_active) begin
                    m_neg = 1; m_active = 1;
`endif
                end else begin
                    m_err = 1; m_active = 1;
                end
            end
            if (term_acc) ov_exp = 1;
            else if (ov_exp && out_ready) ov_exp = 0;
            rdy_ok = 1;
        end
    end

    task automatic send(input logic [7:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_char  = c;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: char 0x%0h not accepted within 50 cycles", c);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic expect_word(input string nm, input int n0, input int b, input int d, input bit e, input bit ng);
        repeat (3) @(negedge clk);
        chk({nm, "_count"}, nwords, n0 + 1);
        chk({nm, "_bcd"}, last_bcd, b);
        chk({nm, "_digits"}, last_dig, d);
        chk({nm, "_err"}, {31'd0, last_err}, {31'd0, e});
        chk({nm, "_neg"}, {31'd0, last_neg}, {31'd0, ng});
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        n0 = nwords; send_str("123\r");
        expect_word("w123", n0, 32'h0123, 3, 0, 0);

        n0 = nwords; send_str("98765\n");
        expect_word("ovf", n0, 32'h9876, 4, 1, 0);

        n0 = nwords; send_str("4A2 ");
        expect_word("inv", n0, 32'h0042, 2, 1, 0);
        n0 = nwords; send(8'h0D);
        repeat (3) @(negedge clk);
        chk("lone_cr_no_word", nwords, n0);
        @(posedge clk); #1;

        n0 = nwords; send_str("007 ");
        expect_word("lead0", n0, 32'h0007, 3, 0, 0);
        n0 = nwords; send_str("1234\r\n");
        expect_word("full", n0, 32'h1234, 4, 0, 0);
        n0 = nwords; send_str("x\r");
        expect_word("onlybad", n0, 0, 0, 1, 0);

        out_ready = 1'b0;
        n0 = nwords; send_str("5\r");
        in_valid = 1'b1; in_char = "7";
        repeat (5) @(negedge clk);
        chk("hold_valid", {31'd0, out_valid}, 1);
        chk("hold_bcd", {16'd0, out_bcd}, 32'h0005);
        chk("hold_count", nwords, n0 + 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send("7");
        n0 = nwords; send(8'h0D);
        expect_word("after_hold", n0, 32'h0007, 1, 0, 0);

        send_str("31");
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = nwords; send_str("8\r");
        expect_word("after_rst", n0, 32'h0008, 1, 0, 0);

`ifdef ASCII_BCD_SIGN_EN
        n0 = nwords; send_str("-42\r");
        expect_word("neg", n0, 32'h0042, 2, 0, 1);
        n0 = nwords; send_str("4-\r");
        expect_word("late_minus", n0, 32'h0004, 1, 1, 0);
`else
        n0 = nwords; send_str("-4\r");
        expect_word("minus_bad", n0, 32'h0004, 1, 1, 0);
`endif

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
